// File: rtl/cmos_pack.sv
`default_nettype none
// ============================================================================
// Module   : cmos_pack
// Purpose  : Write-side pixel packer for the DDR3 video path. Registers the
//            camera pixel bus, packs 16 RGB565 pixels into one 256-bit word
//            (first pixel in bits [255:240]) and strobes it into the write-DMA
//            FIFO. Also emits a frame-boundary pulse and a sticky overflow
//            flag for words dropped while the FIFO was full.
// Revision : 1.0 - initial release
// Options  : PACK_PAD_FLUSH_EN - when defined, a partial word left over at a
//            frame boundary is written left-aligned and zero padded; when
//            undefined it is silently discarded.
// Ports    :
//   cmos_clk     in   1    pixel clock, all logic on rising edge
//   rst          in   1    synchronous reset, active-high
//   cmos_vsync   in   1    frame sync, rising edge marks a frame boundary
//   cmos_de      in   1    pixel valid
//   cmos_data    in   IW   RGB565 pixel
//   fifo_full    in   1    write-FIFO full
//   fifo_wr_en   out  1    one-cycle write strobe
//   fifo_wr_data out  OW   packed word, held between writes
//   frame_start  out  1    one-cycle pulse per accepted frame boundary
//   ovf          out  1    sticky: a word was dropped due to fifo_full
// ============================================================================
module cmos_pack #(
    parameter int IW = 16,
    parameter int OW = 256
) (
    input  logic          cmos_clk,
    input  logic          rst,
    input  logic          cmos_vsync,
    input  logic          cmos_de,
    input  logic [IW-1:0] cmos_data,
    input  logic          fifo_full,
    output logic          fifo_wr_en,
    output logic [OW-1:0] fifo_wr_data,
    output logic          frame_start,
    output logic          ovf
);

    localparam logic [3:0] c_LAST_SLOT = 4'd15;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_vs;
    logic          r_vs_d;
    logic          r_de;
    logic [IW-1:0] r_data;

    logic [3:0]    r_pix_cnt;
    logic [OW-1:0] r_shift_reg;

    logic          r_wr_en;
    logic [OW-1:0] r_wr_data;
    logic          r_frame_start;
    logic          r_ovf;

    logic          w_vs_rise;
    logic          w_accept;
    logic          w_flush;
    logic          w_frame_start;
    logic          w_word_done;
    logic [OW-1:0] w_candidate;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    always_ff @(posedge cmos_clk) begin
        if (rst) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_de   <= 1'b0;
            r_data <= '0;
        end else begin
            r_vs   <= cmos_vsync;
            r_vs_d <= r_vs;
            r_de   <= cmos_de;
            r_data <= cmos_data;
        end
    end

    assign w_vs_rise = r_vs & ~r_vs_d;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge cmos_clk) begin
        if (rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_flush       = 1'b0;
        w_frame_start = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_vs_rise) begin
                    w_state_next  = S_ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                // vsync high wins over de: such pixels are dropped
                w_accept = r_de & ~r_vs;
                if (w_vs_rise) begin
                    w_frame_start = 1'b1;
                    if (r_pix_cnt != 4'd0) begin
                        w_state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_flush      = 1'b1;
                w_state_next = S_ACTIVE;
            end
            default: begin
                w_state_next = S_SYNC;
            end
        endcase
    end

    // Word completes on the 16th accepted pixel; the incoming pixel is the
    // last slot, so the candidate is built from the shifted register.
    assign w_word_done = w_accept && (r_pix_cnt == c_LAST_SLOT);
    assign w_candidate = {r_shift_reg[OW-IW-1:0], r_data};

`ifdef PACK_PAD_FLUSH_EN
    // Left-align k held pixels: shift by 16*(16-k). Since k is never 0 in
    // S_FLUSH, (16-k) equals the 4-bit two's complement of k.
    logic [7:0] w_pad_shamt;
    assign w_pad_shamt = {4'd0 - r_pix_cnt, 4'd0};
`endif

    // ------------------------------------------------------------------
    // Packing and write datapath
    // ------------------------------------------------------------------
    always_ff @(posedge cmos_clk) begin
        if (rst) begin
            r_pix_cnt     <= 4'd0;
            r_shift_reg   <= '0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= '0;
            r_frame_start <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_frame_start <= w_frame_start;
            r_wr_en       <= 1'b0;

            if (w_accept) begin
                r_shift_reg <= w_candidate;
                r_pix_cnt   <= r_pix_cnt + 4'd1;
            end

            if (w_flush) begin
                r_pix_cnt <= 4'd0;
            end

            if (w_word_done) begin
                if (fifo_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_candidate;
                end
            end

`ifdef PACK_PAD_FLUSH_EN
            if (w_flush) begin
                if (fifo_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= r_shift_reg << w_pad_shamt;
                end
            end
`endif
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign frame_start  = r_frame_start;
    assign ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cmos_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_pack
// Purpose  : Self-checking bench for cmos_pack. Each scenario builds a
//            per-cycle stimulus list, plays it into the DUT while recording
//            writes and frame_start pulses, then compares them against a
//            frame/pixel-level reference model of the packer. Honours
//            PACK_PAD_FLUSH_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_pack;

    logic         cmos_clk   = 1'b0;
    logic         rst        = 1'b1;
    logic         cmos_vsync = 1'b0;
    logic         cmos_de    = 1'b0;
    logic [15:0]  cmos_data  = 16'h0;
    logic         fifo_full  = 1'b0;
    logic         fifo_wr_en;
    logic [255:0] fifo_wr_data;
    logic         frame_start;
    logic         ovf;

    always #5 cmos_clk = ~cmos_clk;

    cmos_pack dut (
        .cmos_clk     (cmos_clk),
        .rst          (rst),
        .cmos_vsync   (cmos_vsync),
        .cmos_de      (cmos_de),
        .cmos_data    (cmos_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_start  (frame_start),
        .ovf          (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge cmos_clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [255:0] d;
    } wr_t;

    wr_t got_wr[$];
    wr_t exp_wr[$];
    int  got_fs[$];
    int  exp_fs[$];
    int  ovf_ev[$];
    bit  exp_ovf;
    bit  mon_en = 1'b0;
    int  base;
    wr_t mon_t;

    bit          s_rst[$];
    bit          s_vs[$];
    bit          s_de[$];
    bit          s_full[$];
    logic [15:0] s_dat[$];

    always @(negedge cmos_clk) begin
        if (mon_en) begin
            if (fifo_wr_en === 1'b1) begin
                mon_t.c = cyc;
                mon_t.d = fifo_wr_data;
                got_wr.push_back(mon_t);
            end
            if (frame_start === 1'b1) got_fs.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus building
    // ------------------------------------------------------------------
    task automatic clear_stim();
        s_rst.delete(); s_vs.delete(); s_de.delete(); s_full.delete(); s_dat.delete();
    endtask

    task automatic put(input bit r, input bit v, input bit d, input logic [15:0] x, input bit f);
        s_rst.push_back(r); s_vs.push_back(v); s_de.push_back(d);
        s_dat.push_back(x); s_full.push_back(f);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic add_rst(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic add_vs(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic add_px(input logic [15:0] first, input int n, input bit f);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b1, first + 16'(i), f);
    endtask

    // ------------------------------------------------------------------
    // Reference model: walks the pin-level sequence frame by frame.
    // Index i is sampled on the edge that makes cyc == base+i; a word
    // completed by pixel i appears at base+i+1 (full sampled at i+1), a
    // frame boundary at i pulses frame_start at base+i+1 and a flush write
    // lands at base+i+2 (full sampled at i+2).
    // ------------------------------------------------------------------
    task automatic model();
        logic [15:0]  px[$];
        logic [255:0] word;
        bit           synced;
        bit           prev_vs;
        bit           rise;
        bit           full;
        int           skip;
        int           n;
        wr_t          w;
        n = s_rst.size();
        exp_wr.delete(); exp_fs.delete(); ovf_ev.delete();
        synced = 1'b0; prev_vs = 1'b0; skip = -1;
        for (int i = 0; i < n; i++) begin
            if (s_rst[i]) begin
                for (int k = exp_wr.size() - 1; k >= 0; k--)
                    if (exp_wr[k].c >= base + i) exp_wr.delete(k);
                for (int k = exp_fs.size() - 1; k >= 0; k--)
                    if (exp_fs[k] >= base + i) exp_fs.delete(k);
                ovf_ev.delete(); px.delete();
                synced = 1'b0; prev_vs = 1'b0; skip = -1;
                continue;
            end
            rise = s_vs[i] && !prev_vs;
            if (rise) begin
                exp_fs.push_back(base + i + 1);
                if (synced && px.size() != 0) begin
                    skip = i + 1;
`ifdef PACK_PAD_FLUSH_EN
                    full = (i + 2 < n) ? s_full[i+2] : 1'b0;
                    word = '0;
                    foreach (px[k]) word[255-16*k -: 16] = px[k];
                    w.c = base + i + 2;
                    w.d = word;
                    if (full) ovf_ev.push_back(w.c);
                    else      exp_wr.push_back(w);
`endif
                end
                px.delete();
                synced = 1'b1;
            end else if (synced && s_de[i] && !s_vs[i] && i != skip) begin
                px.push_back(s_dat[i]);
                if (px.size() == 16) begin
                    full = (i + 1 < n) ? s_full[i+1] : 1'b0;
                    word = '0;
                    foreach (px[k]) word[255-16*k -: 16] = px[k];
                    w.c = base + i + 1;
                    w.d = word;
                    if (full) ovf_ev.push_back(w.c);
                    else      exp_wr.push_back(w);
                    px.delete();
                end
            end
            prev_vs = s_vs[i];
        end
        exp_ovf = (ovf_ev.size() != 0);
    endtask

    task automatic run_stim();
        add_idle(4);
        got_wr.delete(); got_fs.delete();
        base   = cyc + 1;
        mon_en = 1'b1;
        for (int i = 0; i < s_rst.size(); i++) begin
            rst        = s_rst[i];
            cmos_vsync = s_vs[i];
            cmos_de    = s_de[i];
            cmos_data  = s_dat[i];
            fifo_full  = s_full[i];
            @(posedge cmos_clk);
            #1;
        end
        @(negedge cmos_clk);
        #1;
        mon_en = 1'b0;
        model();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge cmos_clk);
        #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset wr_en: got %b, expected 0", fifo_wr_en); end
        n_cmp++; if (fifo_wr_data !== 256'h0) begin n_err++; $display("FAIL reset wr_data: got %h, expected 0", fifo_wr_data); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset frame_start: got %b, expected 0", frame_start); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset ovf: got %b, expected 0", ovf); end
    endtask

    task automatic test_full_line();
        clear_stim();
        add_rst(2); add_idle(2); add_vs(2); add_idle(1);
        add_px(16'h0001, 32, 1'b0);
        run_stim();
        n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL full_line wr_count: got %0d, expected %0d", got_wr.size(), exp_wr.size()); end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_cmp++;
            if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL full_line wr[%0d]: got @%0d %h, expected @%0d %h", k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
        end
        n_cmp++; if (got_fs.size() !== exp_fs.size()) begin n_err++; $display("FAIL full_line fs_count: got %0d, expected %0d", got_fs.size(), exp_fs.size()); end
        foreach (exp_fs[k]) if (k < got_fs.size()) begin
            n_cmp++; if (got_fs[k] !== exp_fs[k]) begin n_err++; $display("FAIL full_line fs[%0d]: got @%0d, expected @%0d", k, got_fs[k], exp_fs[k]); end
        end
        n_cmp++; if (got_wr.size() !== 2) begin n_err++; $display("FAIL full_line writes: got %0d, expected 2", got_wr.size()); end
        if (got_wr.size() >= 2) begin
            n_cmp++; if (got_wr[0].d[255:240] !== 16'h0001) begin n_err++; $display("FAIL full_line w0_top: got %h, expected 0001", got_wr[0].d[255:240]); end
            n_cmp++; if (got_wr[0].d[15:0] !== 16'h0010) begin n_err++; $display("FAIL full_line w0_bot: got %h, expected 0010", got_wr[0].d[15:0]); end
            n_cmp++; if (got_wr[1].d[255:240] !== 16'h0011) begin n_err++; $display("FAIL full_line w1_top: got %h, expected 0011", got_wr[1].d[255:240]); end
        end
        if (exp_wr.size() > 0) begin
            n_cmp++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== exp_wr[$].d) begin n_err++; $display("FAIL full_line hold: got en=%b %h, expected en=0 %h", fifo_wr_en, fifo_wr_data, exp_wr[$].d); end
        end
    endtask

    task automatic test_presync();
        clear_stim();
        add_rst(2); add_idle(2);
        add_px(16'h5001, 16, 1'b0);
        add_idle(2);
        run_stim();
        n_cmp++; if (got_wr.size() !== 0) begin n_err++; $display("FAIL presync writes: got %0d, expected 0", got_wr.size()); end
        n_cmp++; if (got_fs.size() !== 0) begin n_err++; $display("FAIL presync frame_start: got %0d pulses, expected 0", got_fs.size()); end
    endtask

    task automatic test_partial_flush();
        clear_stim();
        add_rst(2); add_idle(2); add_vs(2); add_idle(1);
        add_px(16'hA001, 5, 1'b0);
        add_vs(2); add_idle(2);
        run_stim();
        n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL flush wr_count: got %0d, expected %0d", got_wr.size(), exp_wr.size()); end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_cmp++;
            if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL flush wr[%0d]: got @%0d %h, expected @%0d %h", k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
        end
        n_cmp++; if (got_fs.size() !== 2) begin n_err++; $display("FAIL flush fs_count: got %0d, expected 2", got_fs.size()); end
        foreach (exp_fs[k]) if (k < got_fs.size()) begin
            n_cmp++; if (got_fs[k] !== exp_fs[k]) begin n_err++; $display("FAIL flush fs[%0d]: got @%0d, expected @%0d", k, got_fs[k], exp_fs[k]); end
        end
`ifdef PACK_PAD_FLUSH_EN
        n_cmp++; if (got_wr.size() !== 1) begin n_err++; $display("FAIL flush pad_writes: got %0d, expected 1", got_wr.size()); end
        if (got_wr.size() >= 1) begin
            n_cmp++; if (got_wr[0].d[255:176] !== 80'hA001A002A003A004A005) begin n_err++; $display("FAIL flush pad_pixels: got %h, expected a001a002a003a004a005", got_wr[0].d[255:176]); end
            n_cmp++; if (got_wr[0].d[175:0] !== 176'h0) begin n_err++; $display("FAIL flush pad_zero: got %h, expected 0", got_wr[0].d[175:0]); end
        end
`else
        n_cmp++; if (got_wr.size() !== 0) begin n_err++; $display("FAIL flush discard: got %0d writes, expected 0", got_wr.size()); end
`endif
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL flush ovf: got %b, expected 0", ovf); end
    endtask

    task automatic test_overflow();
        clear_stim();
        add_rst(2); add_idle(2); add_vs(2); add_idle(1);
        add_px(16'hC001, 16, 1'b1);
        put(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        add_px(16'hD001, 16, 1'b0);
        add_idle(6);
        run_stim();
        n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL overflow wr_count: got %0d, expected %0d", got_wr.size(), exp_wr.size()); end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_cmp++;
            if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL overflow wr[%0d]: got @%0d %h, expected @%0d %h", k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
        end
        n_cmp++; if (got_wr.size() !== 1) begin n_err++; $display("FAIL overflow writes: got %0d, expected 1", got_wr.size()); end
        if (got_wr.size() >= 1) begin
            n_cmp++; if (got_wr[0].d[255:240] !== 16'hD001 || got_wr[0].d[15:0] !== 16'hD010) begin n_err++; $display("FAIL overflow next_word: got %h, expected d001..d010", got_wr[0].d); end
        end
        n_cmp++; if (ovf !== 1'b1 || exp_ovf !== 1'b1) begin n_err++; $display("FAIL overflow sticky: got %b, expected 1", ovf); end
        clear_stim();
        add_rst(1); add_idle(1);
        run_stim();
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL overflow clear: got %b, expected 0", ovf); end
    endtask

    task automatic test_mid_reset();
        clear_stim();
        add_rst(2); add_idle(2); add_vs(2); add_idle(1);
        add_px(16'h7001, 7, 1'b0);
        add_rst(1);
        add_px(16'h8001, 16, 1'b0);
        add_idle(2); add_vs(2); add_idle(1);
        add_px(16'hE001, 16, 1'b0);
        run_stim();
        n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL mid_reset wr_count: got %0d, expected %0d", got_wr.size(), exp_wr.size()); end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_cmp++;
            if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL mid_reset wr[%0d]: got @%0d %h, expected @%0d %h", k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
        end
        n_cmp++; if (got_fs.size() !== exp_fs.size()) begin n_err++; $display("FAIL mid_reset fs_count: got %0d, expected %0d", got_fs.size(), exp_fs.size()); end
        foreach (exp_fs[k]) if (k < got_fs.size()) begin
            n_cmp++; if (got_fs[k] !== exp_fs[k]) begin n_err++; $display("FAIL mid_reset fs[%0d]: got @%0d, expected @%0d", k, got_fs[k], exp_fs[k]); end
        end
        n_cmp++; if (got_wr.size() !== 1) begin n_err++; $display("FAIL mid_reset writes: got %0d, expected 1", got_wr.size()); end
        if (got_wr.size() >= 1) begin
            n_cmp++; if (got_wr[0].d[255:240] !== 16'hE001 || got_wr[0].d[15:0] !== 16'hE010) begin n_err++; $display("FAIL mid_reset word: got %h, expected e001..e010", got_wr[0].d); end
        end
    endtask

    task automatic test_overlap();
        clear_stim();
        add_rst(2); add_idle(2); add_vs(2); add_idle(1);
        add_px(16'h1001, 16, 1'b0);
        for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        add_idle(1);
        add_px(16'h2001, 8, 1'b0);
        for (int i = 0; i < 2; i++) put(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        add_idle(1);
        add_px(16'h3001, 16, 1'b0);
        run_stim();
        n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL overlap wr_count: got %0d, expected %0d", got_wr.size(), exp_wr.size()); end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_cmp++;
            if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL overlap wr[%0d]: got @%0d %h, expected @%0d %h", k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
        end
        foreach (got_wr[k]) begin
            bit seen;
            seen = 1'b0;
            for (int s = 0; s < 16; s++) if (got_wr[k].d[255-16*s -: 16] === 16'hFFFF) seen = 1'b1;
            n_cmp++; if (seen) begin n_err++; $display("FAIL overlap no_ffff[%0d]: got %h, expected no ffff slot", k, got_wr[k].d); end
        end
        n_cmp++; if (got_fs.size() !== exp_fs.size()) begin n_err++; $display("FAIL overlap fs_count: got %0d, expected %0d", got_fs.size(), exp_fs.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int vs_left;
            clear_stim();
            add_rst(2); add_idle(2); add_vs(2);
            vs_left = 0;
            for (int i = 0; i < 500; i++) begin
                bit f;
                f = ($urandom_range(0, 7) == 0);
                if (vs_left > 0) begin
                    put(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), f);
                    vs_left--;
                end else if ($urandom_range(0, 59) == 0) begin
                    vs_left = int'($urandom_range(2, 4));
                    put(1'b0, 1'b0, 1'b0, 16'h0, f);
                end else begin
                    put(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), f);
                end
            end
            run_stim();
            n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_err++; $display("FAIL random%0d wr_count: got %0d, expected %0d", it, got_wr.size(), exp_wr.size()); end
            foreach (exp_wr[k]) if (k < got_wr.size()) begin
                n_cmp++;
                if (got_wr[k].c !== exp_wr[k].c || got_wr[k].d !== exp_wr[k].d) begin n_err++; $display("FAIL random%0d wr[%0d]: got @%0d %h, expected @%0d %h", it, k, got_wr[k].c, got_wr[k].d, exp_wr[k].c, exp_wr[k].d); end
            end
            n_cmp++; if (got_fs.size() !== exp_fs.size()) begin n_err++; $display("FAIL random%0d fs_count: got %0d, expected %0d", it, got_fs.size(), exp_fs.size()); end
            foreach (exp_fs[k]) if (k < got_fs.size()) begin
                n_cmp++; if (got_fs[k] !== exp_fs[k]) begin n_err++; $display("FAIL random%0d fs[%0d]: got @%0d, expected @%0d", it, k, got_fs[k], exp_fs[k]); end
            end
            n_cmp++; if (ovf !== exp_ovf) begin n_err++; $display("FAIL random%0d ovf: got %b, expected %b", it, ovf, exp_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_presync();
        test_partial_flush();
        test_overflow();
        test_mid_reset();
        test_overlap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmos_pack.md
# cmos_pack

Upstream write-side packer for the DDR3 video path. Accepts 16-bit RGB565 pixels in the camera pixel clock domain, packs 16 consecutive pixels into one 256-bit word, and writes it to the write-DMA FIFO. Pixel order matches the HDMI read-side unpacker: the first pixel of each word lands in bits [255:240]. The block also produces frame-boundary signalling and overflow status for the write DMA.

## Interface
- Iw, 16, input pixel width; fixed, other values unsupported
- Ow, 256, packed word width; Ow/Iw = 16 pixels per word

- cmos_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmos_vsync  in  1  frame sync, active-high; rising edge marks frame boundary
- cmos_de  in  1  pixel valid
- cmos_data  in  16  pixel, sampled when cmos_de=1
- fifo_full  in  1  write-FIFO full
- fifo_wr_en  out  1  one-cycle write strobe
- fifo_wr_data  out  256  packed word
- frame_start  out  1  one-cycle pulse on each accepted frame boundary
- ovf  out  1  sticky: a word was dropped because fifo_full was set

## Operation
- Input registers: cmos_vsync, cmos_de and cmos_data are registered once. vs_rise = registered vsync is 1 and previous registered vsync is 0.
- State machine:
  - S_SYNC: reset state. Pixels are ignored. On vs_rise, go to S_ACTIVE and pulse frame_start.
  - S_ACTIVE: a pixel is accepted when registered de=1 and registered vsync=0. Pixels with de=1 while vsync=1 are discarded. On vs_rise, go to S_FLUSH if pix_cnt≠0; otherwise stay in S_ACTIVE. frame_start pulses in both cases.
  - S_FLUSH: lasts one cycle. Performs the end-of-frame action (see Configuration), clears pix_cnt, then returns to S_ACTIVE.
- Packing:
  - Each accepted pixel does shift_reg <= {shift_reg[239:0], pixel} and pix_cnt <= pix_cnt+1.
  - pix_cnt is 4 bits and wraps from 15 to 0.
  - When the 16th pixel is accepted (pix_cnt=15), the completed word {shift_reg[239:0], pixel} is the write candidate.
- Write:
  - If fifo_full=0 in the cycle the candidate forms, fifo_wr_en=1 and fifo_wr_data=candidate on the next cycle.
  - If fifo_full=1, the word is dropped, ovf is set, and packing continues unaffected.
- ovf is cleared only by rst.
- Writes are always at least 2 cycles apart, so fifo_full sampled one cycle ahead is safe.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=0, frame_start=0, ovf=0; internally state=S_SYNC, pix_cnt=0, shift_reg=0.
- Latency: 16th pixel on the cmos pins at cycle t → fifo_wr_en high at t+2. That is one cycle of input registering plus one cycle of output registering.
- frame_start is high at t+2 for a vsync rising on the pins at cycle t.
- fifo_wr_data holds its last value when fifo_wr_en=0.
- Continuous de over 1280 pixels gives exactly 80 writes, one every 16 cycles.
- Reset mid-frame discards any partial word and returns to S_SYNC. Nothing is written until the next vsync rise has occurred and then a full word (or a flush) completes.
- A vsync rise in the same registered cycle as a de pixel: the pixel is discarded because vsync=1 has priority.
- Flush write (if enabled): fifo_wr_en=1 one cycle after S_FLUSH. It is subject to the same fifo_full drop rule, and is also the cycle after frame_start.

## Configuration
- PACK_PAD_FLUSH_EN defined: in S_FLUSH, a partial word is left-aligned and written with zeros in the unused low pixel slots.
  - With k pixels held, the word is shift_reg << (16·(16−k)).
  - The pixels occupy the top k·16 bits, in order.
- Undefined: in S_FLUSH, the partial word is silently discarded and no write occurs. ovf is not set.

## Test plan
- Full line: rst 1→0, vsync pulse, then 32 pixels 0x0001..0x0020 with de=1 and fifo_full=0 → exactly 2 writes.
  - First word [255:240]=0x0001 and [15:0]=0x0010.
  - Second word [255:240]=0x0011.
  - Each fifo_wr_en is 2 cycles after the 16th pixel.
- Pre-sync: 16 pixels before any vsync rise → no write. frame_start stays 0 until the first vsync rise.
- Partial flush: 5 pixels 0xA001..0xA005, then vsync rise.
  - With PACK_PAD_FLUSH_EN: one write with [255:176]=A001..A005 in order and [175:0]=0.
  - Without the macro: no write.
  - In both cases frame_start pulses once.
- Overflow: fifo_full=1 while the 16th pixel is accepted → no fifo_wr_en and ovf=1.
  - The next 16 pixels with fifo_full=0 are written correctly.
  - ovf stays 1 until rst.
- Mid-frame reset: rst asserted for 1 cycle after 7 pixels → all outputs return to reset values.
  - After a new vsync rise and 16 pixels, exactly one write containing only the new pixels.
- Vsync/de overlap: de=1 with pixel 0xFFFF during vsync high → pixel absent from all written words, and pix_cnt is unchanged.
